// File: rtl/jogador_automatico.sv
// Autonomous player for the sequence-memory game: starts a round, replays a
// fixed 16-move one-hot sequence as timed key presses and latches the verdict.
module jogador_automatico #(
    parameter int N_JOGADAS = 16,
    parameter int T_INICIAR = 5,
    parameter int T_PRESS   = 10,
    parameter int T_GAP     = 10,
    parameter int T_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       comecar,
    input  logic       erro_en,
    input  logic [3:0] erro_idx,
    input  logic       pronto,
    input  logic       acertou,
    input  logic       errou,
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic       terminou,
    output logic       viu_acerto,
    output logic       viu_erro,
    output logic       timeout,
    output logic [3:0] db_jogada,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        IDLE      = 4'h0,
        INICIA    = 4'h1,
        ESPERA    = 4'h2,
        PRESSIONA = 4'h3,
        SOLTA     = 4'h4,
        AGUARDA   = 4'h5,
        FIM       = 4'hF
    } estado_t;

    localparam logic [7:0] LIM_INICIAR = 8'(T_INICIAR - 1);
    localparam logic [7:0] LIM_PRESS   = 8'(T_PRESS - 1);
    localparam logic [7:0] LIM_GAP     = 8'(T_GAP - 1);
    localparam logic [7:0] LIM_TIMEOUT = 8'(T_TIMEOUT - 1);
    localparam logic [3:0] ULTIMA      = 4'(N_JOGADAS - 1);

    estado_t    estado;
    logic [7:0] timer;
    logic [3:0] idx;
    logic       pronto_valido;

    function automatic logic [3:0] rom(input logic [3:0] i);
        logic [3:0] k;
        case (i)
            4'd0:    k = 4'b0001;
            4'd1:    k = 4'b0010;
            4'd2:    k = 4'b0100;
            4'd3:    k = 4'b1000;
            4'd4:    k = 4'b0100;
            4'd5:    k = 4'b0010;
            4'd6:    k = 4'b0001;
            4'd7:    k = 4'b0001;
            4'd8:    k = 4'b0010;
            4'd9:    k = 4'b0010;
            4'd10:   k = 4'b0100;
            4'd11:   k = 4'b0100;
            4'd12:   k = 4'b1000;
            4'd13:   k = 4'b1000;
            4'd14:   k = 4'b0001;
            default: k = 4'b0100;
        endcase
        return k;
    endfunction

    // Wrong key used for injection: the neighbour key, wrapping 1000 -> 0001.
    function automatic logic [3:0] rot_esq(input logic [3:0] k);
        return {k[2:0], k[3]};
    endfunction

    function automatic logic [3:0] tecla(input logic [3:0] i, input logic inj);
        return inj ? rot_esq(rom(i)) : rom(i);
    endfunction

    assign pronto_valido = pronto && (estado == ESPERA || estado == PRESSIONA ||
                                      estado == SOLTA  || estado == AGUARDA);

    assign db_estado = estado;
    assign db_jogada = idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= IDLE;
            timer      <= '0;
            idx        <= '0;
            iniciar    <= 1'b0;
            chaves     <= '0;
            terminou   <= 1'b0;
            viu_acerto <= 1'b0;
            viu_erro   <= 1'b0;
            timeout    <= 1'b0;
        end else if (pronto_valido) begin
            // The game's verdict beats every timer exit and releases the key at once.
            estado     <= FIM;
            timer      <= '0;
            chaves     <= '0;
            terminou   <= 1'b1;
            viu_acerto <= acertou;
            viu_erro   <= errou;
        end else begin
            timer <= timer + 8'd1;
            case (estado)
                IDLE, FIM: begin
                    if (comecar) begin
                        estado     <= INICIA;
                        timer      <= '0;
                        idx        <= '0;
                        iniciar    <= 1'b1;
                        terminou   <= 1'b0;
                        viu_acerto <= 1'b0;
                        viu_erro   <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                INICIA: begin
                    if (timer == LIM_INICIAR) begin
                        estado  <= ESPERA;
                        timer   <= '0;
                        iniciar <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (timer == LIM_GAP) begin
                        estado <= PRESSIONA;
                        timer  <= '0;
                        chaves <= tecla(idx, erro_en && (idx == erro_idx));
                    end
                end
                PRESSIONA: begin
                    if (timer == LIM_PRESS) begin
                        estado <= SOLTA;
                        timer  <= '0;
                        chaves <= '0;
                    end
                end
                SOLTA: begin
                    timer <= '0;
                    if (idx == ULTIMA) begin
                        estado <= AGUARDA;
                    end else begin
                        estado <= ESPERA;
                        idx    <= idx + 4'd1;
                    end
                end
                AGUARDA: begin
                    if (timer == LIM_TIMEOUT) begin
                        estado   <= FIM;
                        timer    <= '0;
                        timeout  <= 1'b1;
                        terminou <= 1'b1;
                    end
                end
                default: begin
                    estado <= IDLE;
                    timer  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a game model scores each press against a queue of
// expected keys; round-level vectors come from a table, corner cases are hand-written.
module tb_jogador_automatico;

    localparam int T_PRESS = 10;
    localparam int T_GAP   = 10;
    localparam int SILENT  = 0;
    localparam int WIN     = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       comecar;
    logic       erro_en;
    logic [3:0] erro_idx;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       iniciar;
    logic [3:0] chaves;
    logic       terminou;
    logic       viu_acerto;
    logic       viu_erro;
    logic       timeout;
    logic [3:0] db_jogada;
    logic [3:0] db_estado;

    logic tb_pronto;
    logic m_pronto, m_acertou, m_errou;
    logic model_on;
    int   model_mode;

    assign pronto  = tb_pronto | m_pronto;
    assign acertou = m_acertou;
    assign errou   = m_errou;

    jogador_automatico dut (
        .clock(clock), .reset(reset), .comecar(comecar), .erro_en(erro_en),
        .erro_idx(erro_idx), .pronto(pronto), .acertou(acertou), .errou(errou),
        .iniciar(iniciar), .chaves(chaves), .terminou(terminou),
        .viu_acerto(viu_acerto), .viu_erro(viu_erro), .timeout(timeout),
        .db_jogada(db_jogada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [3:0] rom_tb [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                4'b1000, 4'b1000, 4'b0001, 4'b0100};
    logic [3:0] exp_q[$];

    task automatic push_round(input logic en, input logic [3:0] ei);
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            v = rom_tb[i];
            if (en && i == int'(ei)) v = {v[2:0], v[3]};
            exp_q.push_back(v);
        end
    endtask

    // Game model: checks every press against the queue and the game's own ROM.
    logic [3:0] prev, cur, e;
    int plen, glen, n_press, cd, ini_cnt;
    logic prev_ini;
    always @(negedge clock) begin
        if (reset || !model_on) begin
            m_pronto = 0; m_acertou = 0; m_errou = 0;
            prev = 0; cur = 0; plen = 0; glen = 0; n_press = 0; cd = 0;
            ini_cnt = 0; prev_ini = 0;
        end else begin
            if (iniciar) begin
                n_press = 0; cd = 0;
                ini_cnt = prev_ini ? ini_cnt + 1 : 1;
            end
            prev_ini = iniciar;
            if (chaves != 0) begin
                if (prev == 0) begin
                    if (exp_q.size() == 0) begin
                        check("press_unexpected", int'(chaves), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("press_val", int'(chaves), int'(e));
                    end
                    if (n_press > 0) check("gap_len", glen, T_GAP + 1);
                    cur = chaves; plen = 1;
                    if (n_press < 16 && chaves != rom_tb[n_press]) begin
                        m_pronto = 1; m_errou = 1;
                    end
                end else begin
                    plen++;
                    check("press_stable", int'(chaves), int'(cur));
                end
            end else if (prev != 0) begin
                if (!m_pronto) check("press_width", plen, T_PRESS);
                n_press++;
                glen = 1;
                if (n_press == 16 && model_mode == WIN) cd = 2;
            end else begin
                glen++;
                if (cd != 0) begin
                    cd--;
                    if (cd == 0) begin m_pronto = 1; m_acertou = 1; end
                end
            end
            prev = chaves;
            if (terminou) begin m_pronto = 0; m_acertou = 0; m_errou = 0; end
        end
    end

    typedef struct {
        logic       en;
        logic [3:0] idx;
        int         mode;
        int         cycles;
        logic       acerto;
        logic       erro;
        logic       to;
        int         left;
    } vec_t;
    vec_t vecs[5];

    int start, c1, done;

    task automatic wait_fim(input string name);
        done = 0;
        for (int i = 0; i < 1000 && done == 0; i++) begin
            @(negedge clock);
            if (terminou) done = 1;
        end
        if (done == 0) check({name, "_wait_fim"}, 0, 1);
    endtask

    initial begin
        vecs[0] = '{en: 1'b0, idx: 4'd0,  mode: WIN,    cycles: 343, acerto: 1'b1, erro: 1'b0, to: 1'b0, left: 0};
        vecs[1] = '{en: 1'b1, idx: 4'd3,  mode: WIN,    cycles: 79,  acerto: 1'b0, erro: 1'b1, to: 1'b0, left: 12};
        vecs[2] = '{en: 1'b0, idx: 4'd0,  mode: SILENT, cycles: 596, acerto: 1'b0, erro: 1'b0, to: 1'b1, left: 0};
        vecs[3] = '{en: 1'b1, idx: 4'd0,  mode: WIN,    cycles: 16,  acerto: 1'b0, erro: 1'b1, to: 1'b0, left: 15};
        vecs[4] = '{en: 1'b1, idx: 4'd15, mode: WIN,    cycles: 331, acerto: 1'b0, erro: 1'b1, to: 1'b0, left: 0};

        reset = 1; comecar = 0; erro_en = 0; erro_idx = 0; tb_pronto = 0;
        model_on = 0; model_mode = SILENT;
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("rst_estado", int'(db_estado), 0);
        check("rst_jogada", int'(db_jogada), 0);
        check("rst_iniciar", int'(iniciar), 0);
        check("rst_chaves", int'(chaves), 0);
        check("rst_flags", int'({terminou, viu_acerto, viu_erro, timeout}), 0);

        for (int r = 0; r < 5; r++) begin
            erro_en = vecs[r].en; erro_idx = vecs[r].idx;
            model_mode = vecs[r].mode; model_on = 1;
            push_round(vecs[r].en, vecs[r].idx);
            comecar = 1;
            @(negedge clock);
            comecar = 0; start = cyc;
            wait_fim($sformatf("row%0d", r));
            check($sformatf("row%0d_cycles", r), cyc - start, vecs[r].cycles);
            check($sformatf("row%0d_acerto", r), int'(viu_acerto), int'(vecs[r].acerto));
            check($sformatf("row%0d_erro", r), int'(viu_erro), int'(vecs[r].erro));
            check($sformatf("row%0d_timeout", r), int'(timeout), int'(vecs[r].to));
            check($sformatf("row%0d_estado", r), int'(db_estado), 15);
            check($sformatf("row%0d_chaves", r), int'(chaves), 0);
            check($sformatf("row%0d_iniciar_len", r), ini_cnt, 5);
            check($sformatf("row%0d_left", r), exp_q.size(), vecs[r].left);
            exp_q.delete();
            @(negedge clock);
        end

        // Reset in the middle of the move-3 press.
        model_on = 0; erro_en = 0;
        comecar = 1;
        @(negedge clock);
        comecar = 0; start = cyc;
        repeat (80) @(negedge clock);
        check("mid_estado", int'(db_estado), 3);
        check("mid_jogada", int'(db_jogada), 3);
        check("mid_chaves", int'(chaves), 4'b1000);
        #2 reset = 1;
        #1;
        check("async_chaves", int'(chaves), 0);
        check("async_iniciar", int'(iniciar), 0);
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("post_rst_estado", int'(db_estado), 0);
        check("post_rst_jogada", int'(db_jogada), 0);
        check("post_rst_terminou", int'(terminou), 0);

        // pronto held during INICIA must be ignored.
        comecar = 1; tb_pronto = 1;
        @(negedge clock);
        comecar = 0; start = cyc;
        check("ini_estado", int'(db_estado), 1);
        check("ini_iniciar", int'(iniciar), 1);
        repeat (5) @(negedge clock);
        check("ini_to_espera", int'(db_estado), 2);
        tb_pronto = 0;
        @(negedge clock);
        check("ini_still_espera", int'(db_estado), 2);
        check("ini_no_fim", int'(terminou), 0);
        repeat (9) @(negedge clock);
        check("ini_first_press", int'(chaves), 4'b0001);
        reset = 1;
        @(negedge clock);
        reset = 0;
        @(negedge clock);

        // comecar held high: back-to-back rounds.
        model_on = 1; model_mode = WIN; erro_en = 0;
        push_round(1'b0, 4'd0);
        push_round(1'b0, 4'd0);
        comecar = 1;
        @(negedge clock);
        start = cyc;
        wait_fim("hold1");
        c1 = cyc;
        check("hold1_cycles", c1 - start, 343);
        check("hold1_acerto", int'(viu_acerto), 1);
        check("hold1_jogada", int'(db_jogada), 15);
        @(negedge clock);
        comecar = 0; start = cyc;
        check("hold2_estado", int'(db_estado), 1);
        check("hold2_flag_clear", int'(viu_acerto), 0);
        check("hold2_terminou", int'(terminou), 0);
        check("hold2_jogada", int'(db_jogada), 0);
        wait_fim("hold2");
        check("hold2_cycles", cyc - start, 343);
        check("hold2_acerto", int'(viu_acerto), 1);
        check("hold2_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
